linear_classifier: RTL

Parametrised streaming linear classifier for the MNIST inference datapath. It computes one signed score per class as bias plus the dot product of a feature stream with per-feature weight vectors. It then selects the arg-max class with a sequential comparator and returns the class index and its raw score on an output handshake. It replaces the fixed 10-class/4-bit classifier with configurable class count, widths, feature count and arithmetic modes.

---
 rtl/linear_classifier.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/linear_classifier.sv
// Streaming linear classifier: per-class bias + dot(x, w[class]) accumulated over
// a feature stream, then a one-compare-per-cycle arg-max returned on a handshake.

module lc_lane #(
  parameter int DATA_W = 4,
  parameter int W_W    = 4,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [W_W-1:0]    w_i,
  input  logic              x_signed_i,
  input  logic              sat_i,
  output logic [ACC_W-1:0]  acc_o
);
  localparam int PW = DATA_W + W_W + 1;

  logic signed [DATA_W:0]  x_ext;
  logic signed [PW-1:0]    xp, wp, prod;
  logic signed [ACC_W:0]   sum;

  assign x_ext = x_signed_i ? $signed({x_i[DATA_W-1], x_i}) : $signed({1'b0, x_i});
  assign xp    = PW'(x_ext);
  assign wp    = PW'($signed(w_i));
  assign prod  = xp * wp;
  // one guard bit is enough: |acc| and |prod| are both bounded by 2^(ACC_W-1)
  assign sum   = (ACC_W+1)'($signed(acc_i)) + (ACC_W+1)'(prod);

  always_comb begin
    acc_o = sum[ACC_W-1:0];
    if (sat_i && (sum[ACC_W] != sum[ACC_W-1]))
      acc_o = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
endmodule

module linear_classifier #(
  parameter int NUM_CLASSES  = 10,
  parameter int DATA_W       = 4,
  parameter int W_W          = 4,
  parameter int ACC_W        = 16,
  parameter int NUM_FEATURES = 784,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [2:0]                  configure_i,
  output logic [1:0]                  status_o,
  input  logic [NUM_CLASSES*W_W-1:0]  b_tdata_i,
  input  logic                        b_tvalid_i,
  output logic                        b_tready_o,
  input  logic [DATA_W-1:0]           x_tdata_i,
  input  logic                        x_tvalid_i,
  output logic                        x_tready_o,
  input  logic [NUM_CLASSES*W_W-1:0]  w_tdata_i,
  input  logic                        w_tvalid_i,
  output logic                        w_tready_o,
  output logic [IDX_W-1:0]            a_tdata_o,
  output logic [ACC_W-1:0]            raw_o,
  output logic                        a_tvalid_o,
  input  logic                        a_tready_i
);
  localparam int CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCUM  = 2'b01;
  localparam logic [1:0] ST_ARGMAX = 2'b10;
  localparam logic [1:0] ST_OUTPUT = 2'b11;

  logic [1:0]                        state_q, state_d;
  logic                              live_q;
  logic [1:0]                        cfg_q, cfg_d;
  logic [NUM_CLASSES-1:0][ACC_W-1:0] acc_q, acc_d, acc_mac;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d, best_q, best_d, nxt_best;
  logic [IDX_W-1:0]                  a_tdata_q, a_tdata_d;
  logic [ACC_W-1:0]                  raw_q, raw_d;

  genvar g;
  generate
    for (g = 0; g < NUM_CLASSES; g++) begin : g_lane
      lc_lane #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) u_lane (
        .acc_i      (acc_q[g]),
        .x_i        (x_tdata_i),
        .w_i        (w_tdata_i[g*W_W +: W_W]),
        .x_signed_i (cfg_q[0]),
        .sat_i      (cfg_q[1]),
        .acc_o      (acc_mac[g])
      );
    end
  endgenerate

  // strict '>' keeps the earlier index on ties
  assign nxt_best = ($signed(acc_q[idx_q]) > $signed(acc_q[best_q])) ? idx_q : best_q;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    best_d    = best_q;
    a_tdata_d = a_tdata_q;
    raw_d     = raw_q;
    case (state_q)
      ST_IDLE: if (b_tvalid_i && live_q) begin
        cfg_d = configure_i[1:0];
        for (int i = 0; i < NUM_CLASSES; i++)
          acc_d[i] = configure_i[2] ? '0 : ACC_W'($signed(b_tdata_i[i*W_W +: W_W]));
        cnt_d   = '0;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: if (x_tvalid_i && w_tvalid_i) begin
        acc_d = acc_mac;
        if (cnt_q == CNT_W'(NUM_FEATURES-1)) begin
          state_d = ST_ARGMAX;
          best_d  = '0;
          idx_d   = IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ARGMAX: begin
        best_d = nxt_best;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CLASSES-1)) begin
          a_tdata_d = nxt_best;
          raw_d     = acc_q[nxt_best];
          state_d   = ST_OUTPUT;
        end
      end
      default: if (a_tready_i) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      cfg_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      best_q    <= '0;
      a_tdata_q <= '0;
      raw_q     <= '0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      cfg_q     <= cfg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      a_tdata_q <= a_tdata_d;
      raw_q     <= raw_d;
    end
  end

  // live_q holds b_tready low while in reset and until the first edge after release
  assign status_o   = state_q;
  assign b_tready_o = live_q && (state_q == ST_IDLE);
  assign x_tready_o = (state_q == ST_ACCUM);
  assign w_tready_o = (state_q == ST_ACCUM);
  assign a_tvalid_o = (state_q == ST_OUTPUT);
  assign a_tdata_o  = a_tdata_q;
  assign raw_o      = raw_q;
endmodule
